// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-address select
// encoding and default parameter values.
package pc_sequencer_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_STEP       = 1;
  localparam int unsigned DEF_RAS_DEPTH  = 4;
  localparam int unsigned DEF_RESET_ADDR = 0;

  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_REDIR = 3'd1,
    SEL_RET   = 3'd2,
    SEL_CALL  = 3'd3,
    SEL_BR    = 3'd4,
    SEL_SEQ   = 3'd5
  } nextSel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. Once full, a push silently overwrites the
// oldest entry. Push and pop together replace the top entry in place.
module pc_ras
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         push_data_i,
  output logic [WIDTH-1:0]         top_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d, topIdx, wrIdx;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             wrEn, empty;

  // ptr_q names the next free slot; the top lives one slot below it.
  assign topIdx = ptr_q - PW'(1);
  assign empty  = (count_q == '0);

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    wrEn        = 1'b0;
    wrIdx       = ptr_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (push_i && pop_i) begin
      wrEn = 1'b1;
      if (empty) begin
        underflow_d = 1'b1;
        ptr_d       = ptr_q + PW'(1);
        count_d     = CW'(1);
      end else begin
        wrIdx = topIdx;
      end
    end else if (push_i) begin
      wrEn  = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (count_q == FULL) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (pop_i) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        ptr_d   = topIdx;
        count_d = count_q - CW'(1);
      end
    end
  end

  // Entry storage is not reset; it is unreadable while the count is zero.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem_q[wrIdx] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign top_o       = mem_q[topIdx];
  assign empty_o     = empty;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-address sequencer with stall, redirect, return/call via a
// return-address stack, conditional branches and sequential stepping.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEF_WIDTH,
  parameter int unsigned      STEP       = DEF_STEP,
  parameter int unsigned      RAS_DEPTH  = DEF_RAS_DEPTH,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(DEF_RESET_ADDR)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall_i,
  input  logic                       redirect_i,
  input  logic [WIDTH-1:0]           redirect_addr_i,
  input  logic                       pl_i,
  input  logic                       jb_i,
  input  logic                       bc_i,
  input  logic                       n_i,
  input  logic                       z_i,
  input  logic                       call_i,
  input  logic                       ret_i,
  input  logic [WIDTH-1:0]           offset_i,
  output logic [WIDTH-1:0]           instr_addr_o,
  output logic [$clog2(RAS_DEPTH):0] ras_count_o,
  output logic                       ras_overflow_o,
  output logic                       ras_underflow_o
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  nextSel_e         sel;
  logic [WIDTH-1:0] instrAddr_q, instrAddr_d;
  logic [WIDTH-1:0] seqAddr, relAddr, rasTop;
  logic             rasEmpty, rasPush, rasPop, brTaken;

  // Two's-complement addition makes the offset behave as signed for free.
  assign seqAddr = instrAddr_q + STEP_W;
  assign relAddr = instrAddr_q + offset_i;
  assign brTaken = jb_i | (bc_i ? n_i : z_i);

  always_comb begin
    sel = SEL_SEQ;
    if (stall_i)         sel = SEL_HOLD;
    else if (redirect_i) sel = SEL_REDIR;
    else if (ret_i)      sel = SEL_RET;
    else if (call_i)     sel = SEL_CALL;
    else if (pl_i)       sel = SEL_BR;
  end

  always_comb begin
    instrAddr_d = seqAddr;
    case (sel)
      SEL_HOLD:  instrAddr_d = instrAddr_q;
      SEL_REDIR: instrAddr_d = redirect_addr_i;
      SEL_RET:   instrAddr_d = rasEmpty ? seqAddr : rasTop;
      SEL_CALL:  instrAddr_d = relAddr;
      SEL_BR:    instrAddr_d = brTaken ? relAddr : seqAddr;
      default:   instrAddr_d = seqAddr;
    endcase
  end

  // A call alongside a ret turns the pop into an in-place replace of the top.
  assign rasPush = call_i & ((sel == SEL_RET) | (sel == SEL_CALL));
  assign rasPop  = (sel == SEL_RET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrAddr_q <= RESET_ADDR;
    end else begin
      instrAddr_q <= instrAddr_d;
    end
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rasPush),
    .pop_i       (rasPop),
    .push_data_i (seqAddr),
    .top_o       (rasTop),
    .empty_o     (rasEmpty),
    .count_o     (ras_count_o),
    .overflow_o  (ras_overflow_o),
    .underflow_o (ras_underflow_o)
  );

  assign instr_addr_o = instrAddr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue-based reference model is compared
// every cycle, plus literal expectations at key points of the sequence.
module tb_pc_sequencer;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          stall_i = 1'b0, redirect_i = 1'b0, pl_i = 1'b0, jb_i = 1'b0;
  logic          bc_i = 1'b0, n_i = 1'b0, z_i = 1'b0, call_i = 1'b0, ret_i = 1'b0;
  logic [W-1:0]  redirect_addr_i = '0, offset_i = '0;
  logic [W-1:0]  instr_addr_o;
  logic [CW-1:0] ras_count_o;
  logic          ras_overflow_o, ras_underflow_o;

  int nChecks = 0;
  int nPass   = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH      (W),
    .STEP       (1),
    .RAS_DEPTH  (D),
    .RESET_ADDR (32'd0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .pl_i            (pl_i),
    .jb_i            (jb_i),
    .bc_i            (bc_i),
    .n_i             (n_i),
    .z_i             (z_i),
    .call_i          (call_i),
    .ret_i           (ret_i),
    .offset_i        (offset_i),
    .instr_addr_o    (instr_addr_o),
    .ras_count_o     (ras_count_o),
    .ras_overflow_o  (ras_overflow_o),
    .ras_underflow_o (ras_underflow_o)
  );

  // Reference model: the stack is a queue whose back is the top.
  logic [W-1:0] mPc = '0;
  logic [W-1:0] mStack[$];
  logic         mOvf = 1'b0, mUnf = 1'b0;
  logic [W-1:0] mTgt, mRa;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPc = '0;
      mStack.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else begin
      mOvf = 1'b0;
      mUnf = 1'b0;
      mRa  = mPc + 32'd1;
      if (stall_i) begin
        mPc = mPc;
      end else if (redirect_i) begin
        mPc = redirect_addr_i;
      end else if (ret_i) begin
        if (mStack.size() > 0) begin
          mTgt = mStack.pop_back();
        end else begin
          mTgt = mRa;
          mUnf = 1'b1;
        end
        if (call_i) mStack.push_back(mRa);
        mPc = mTgt;
      end else if (call_i) begin
        mStack.push_back(mRa);
        if (mStack.size() > D) begin
          void'(mStack.pop_front());
          mOvf = 1'b1;
        end
        mPc = mPc + offset_i;
      end else if (pl_i && (jb_i || (bc_i ? n_i : z_i))) begin
        mPc = mPc + offset_i;
      end else begin
        mPc = mRa;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      nChecks++;
      if (instr_addr_o === mPc && ras_count_o === CW'(mStack.size()) &&
          ras_overflow_o === mOvf && ras_underflow_o === mUnf) begin
        nPass++;
      end else begin
        $display("[TB] FAIL model-compare t=%0t: got addr=%h cnt=%0d ovf=%b unf=%b, want addr=%h cnt=%0d ovf=%b unf=%b",
                 $time, instr_addr_o, ras_count_o, ras_overflow_o, ras_underflow_o,
                 mPc, mStack.size(), mOvf, mUnf);
      end
    end
  end

  task automatic clearInputs();
    stall_i = 0; redirect_i = 0; pl_i = 0; jb_i = 0; bc_i = 0;
    n_i = 0; z_i = 0; call_i = 0; ret_i = 0;
    redirect_addr_i = '0; offset_i = '0;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] expAddr,
                             input int expCnt, input logic expOvf, input logic expUnf);
    nChecks++;
    if (instr_addr_o === expAddr && ras_count_o === CW'(expCnt) &&
        ras_overflow_o === expOvf && ras_underflow_o === expUnf) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got addr=%h cnt=%0d ovf=%b unf=%b, want addr=%h cnt=%0d ovf=%b unf=%b",
               name, instr_addr_o, ras_count_o, ras_overflow_o, ras_underflow_o,
               expAddr, expCnt, expOvf, expUnf);
    end
  endtask

  task automatic doRedirect(input logic [W-1:0] a);
    redirect_i = 1; redirect_addr_i = a;
    applyStimulus();
  endtask

  task automatic doBranch(input logic jb, input logic bc, input logic n, input logic z,
                          input logic [W-1:0] off);
    pl_i = 1; jb_i = jb; bc_i = bc; n_i = n; z_i = z; offset_i = off;
    applyStimulus();
  endtask

  task automatic doCall(input logic [W-1:0] off);
    call_i = 1; offset_i = off;
    applyStimulus();
  endtask

  task automatic doRet();
    ret_i = 1;
    applyStimulus();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 checkEn = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("reset", 32'd0, 0, 0, 0);
    rst_n = 1'b1;

    applyStimulus(); checkOutput("seq1", 32'd1, 0, 0, 0);
    applyStimulus(); checkOutput("seq2", 32'd2, 0, 0, 0);
    applyStimulus(); checkOutput("seq3", 32'd3, 0, 0, 0);

    doRedirect(32'd10); checkOutput("redir10", 32'd10, 0, 0, 0);
    doBranch(0, 1, 1, 0, -32'sd4); checkOutput("brN_taken", 32'd6, 0, 0, 0);
    doRedirect(32'd10);
    doBranch(0, 1, 0, 1, -32'sd4); checkOutput("brN_not", 32'd11, 0, 0, 0);

    doRedirect(32'd20);
    doCall(32'd5); checkOutput("call", 32'd25, 1, 0, 0);
    doRet();       checkOutput("ret", 32'd21, 0, 0, 0);
    doRet();       checkOutput("ret_underflow", 32'd22, 0, 0, 1);
    applyStimulus(); checkOutput("underflow_clears", 32'd23, 0, 0, 0);

    doRedirect(32'd0);
    for (int i = 0; i < 4; i++) doCall(32'd10);
    checkOutput("four_calls", 32'd40, 4, 0, 0);
    doCall(32'd10); checkOutput("overflow", 32'd50, 4, 1, 0);
    doRet(); checkOutput("ret41", 32'd41, 3, 0, 0);
    doRet(); checkOutput("ret31", 32'd31, 2, 0, 0);
    doRet(); checkOutput("ret21", 32'd21, 1, 0, 0);
    doRet(); checkOutput("ret11", 32'd11, 0, 0, 0);

    stall_i = 1; redirect_i = 1; redirect_addr_i = 32'd99; call_i = 1; offset_i = 32'd7;
    applyStimulus(); checkOutput("stall_hold", 32'd11, 0, 0, 0);
    doRedirect(32'hFFFF_FFFF); checkOutput("redir_max", 32'hFFFF_FFFF, 0, 0, 0);
    applyStimulus(); checkOutput("wrap", 32'd0, 0, 0, 0);

    doRedirect(32'd6);
    doCall(32'd44); checkOutput("call_to50", 32'd50, 1, 0, 0);
    call_i = 1; ret_i = 1; offset_i = 32'd3;
    applyStimulus(); checkOutput("callret", 32'd7, 1, 0, 0);
    doRet(); checkOutput("ret_replaced", 32'd51, 0, 0, 0);
    call_i = 1; ret_i = 1;
    applyStimulus(); checkOutput("callret_empty", 32'd52, 1, 0, 1);
    doRet(); checkOutput("ret_after_empty_callret", 32'd52, 0, 0, 0);

    doBranch(1, 0, 0, 0, -32'sd60); checkOutput("jump_neg", 32'hFFFF_FFF8, 0, 0, 0);
    doBranch(0, 0, 1, 1, 32'd8);     checkOutput("brZ_taken_wrap", 32'd0, 0, 0, 0);
    doBranch(0, 0, 1, 0, 32'd8);     checkOutput("brZ_not", 32'd1, 0, 0, 0);

    doCall(32'd4); checkOutput("call_before_reset", 32'd5, 1, 0, 0);
    call_i = 1; offset_i = 32'd4;
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 32'd0, 0, 0, 0);
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus(); checkOutput("post_reset_seq", 32'd1, 0, 0, 0);

    @(negedge clk);
    #1 checkEn = 1'b0;
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
